cv32e40p_sleep_cg_ctrl: RTL and testbench
=========================================

Name: cv32e40p_sleep_cg_ctrl

Overview:
Generates the enable for the core clock gate. The gate itself owns the clock buffer and the enable/scan OR.
- Runs on the free-running, ungated clock.
- Accepts the core's sleep request (WFI retired) and waits until the bus interface has drained for a programmable idle window.
- Then drops the clock enable.
- Restores the clock on interrupt or debug wake, with a minimum enabled hold.

Parameters:
IDLE_CYCLES, 4, consecutive non-busy cycles needed in DRAIN before gating (>=1)
WAKE_HOLD, 2, cycles clk_en_o is forced high after a wake before a new sleep is accepted (>=1)

Ports:
clk_i  input  1  free-running (ungated) clock
rst_ni  input  1  asynchronous active-low reset
sleep_req_i  input  1  core requests sleep; level, held while sleeping
busy_i  input  1  outstanding instr/data bus transaction or pending write
wake_i  input  1  pending, enabled interrupt (level)
debug_req_i  input  1  external debug request (level)
clk_en_o  output  1  enable to the clock gate; 1 = clock running
core_sleep_o  output  1  core is clock-gated (status)
gated_cycles_o  output  32  gated-cycle count (optional feature)

Behaviour:
- Reset:
  - Asynchronous; state ACTIVE, clk_en_o=1, core_sleep_o=0.
  - Idle and hold counters = 0; gated_cycles_o=0.
- All outputs are registered. Counter width is $clog2(max(IDLE_CYCLES,WAKE_HOLD)+1).
- Let wake = wake_i | debug_req_i.
- ACTIVE:
  - clk_en_o=1.
  - sleep_req_i & !wake -> DRAIN, idle counter cleared.
  - sleep_req_i & wake in the same cycle -> stay ACTIVE.
- DRAIN:
  - clk_en_o=1.
  - wake or !sleep_req_i -> ACTIVE (abort); checked first.
  - busy_i=1 -> idle counter cleared, stay in DRAIN.
  - Otherwise increment the counter. On the cycle the counter reaches IDLE_CYCLES-1 with busy_i=0 -> GATED.
  - Result: clk_en_o falls at the edge after the IDLE_CYCLES-th consecutive idle cycle.
  - wake in that same final cycle wins -> ACTIVE, no gating.
- GATED:
  - clk_en_o=0, core_sleep_o=1.
  - sleep_req_i and busy_i are ignored; they are frozen in the gated domain.
  - wake -> WAKE. clk_en_o=1 and core_sleep_o=0 at the next edge, so wake latency is 1 cycle.
- WAKE:
  - clk_en_o=1; hold counter counts WAKE_HOLD cycles; sleep_req_i is ignored.
  - On hold done -> ACTIVE. A still-asserted sleep_req_i is evaluated normally from ACTIVE.
- clk_en_o never toggles more than once per cycle. No combinational path from any input to clk_en_o.
- Reset mid-GATED: clk_en_o returns to 1 asynchronously.
- Illegal state encoding -> ACTIVE, clk_en_o=1 (fail-safe: clock runs).

Optional Feature:
Macro RVLAB_CG_STATS_EN.
- Defined:
  - gated_cycles_o increments once per clk_i cycle spent in GATED.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- Undefined:
  - gated_cycles_o is tied to 0 and no counter flops exist.
  - FSM behaviour is identical.

Test Plan:
- Reset release, sleep_req_i=0 -> clk_en_o=1, core_sleep_o=0 indefinitely; gated_cycles_o=0.
- Basic sleep, IDLE_CYCLES=4:
  - Stimulus: sleep_req_i=1 at cycle 0, busy_i=0.
  - Response: DRAIN at cycle 1, clk_en_o=0 and core_sleep_o=1 from cycle 5.
- Busy restart:
  - Stimulus: busy_i pulse for 1 cycle at the 3rd idle cycle.
  - Response: counter restarts; gating occurs 4 idle cycles after busy_i falls.
- Wake latency, WAKE_HOLD=2:
  - Stimulus: wake_i=1 at cycle N while GATED.
  - Response: clk_en_o=1 at N+1. sleep_req_i still 1 -> state ACTIVE at N+3, DRAIN at N+4.
- Simultaneous/abort cases:
  - wake_i rises in the final DRAIN cycle -> clk_en_o stays 1, state ACTIVE.
  - debug_req_i=1 with sleep_req_i=1 in ACTIVE -> never leaves ACTIVE.
- Stats and reset:
  - With RVLAB_CG_STATS_EN, GATED for 10 cycles -> gated_cycles_o=10.
  - rst_ni low mid-GATED -> clk_en_o=1 immediately, counter=0.

Source files
------------

// File: rtl/cv32e40p_sleep_cg_ctrl.sv
// Core clock-gate enable controller: drain, gate, wake with minimum hold.
// Optional gated-cycle statistics counter under RVLAB_CG_STATS_EN.
module cv32e40p_sleep_cg_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_HOLD   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sleep_req_i,
  input  logic        busy_i,
  input  logic        wake_i,
  input  logic        debug_req_i,
  output logic        clk_en_o,
  output logic        core_sleep_o,
  output logic [31:0] gated_cycles_o
);

  localparam int MAXV =
    (IDLE_CYCLES > WAKE_HOLD) ? IDLE_CYCLES : WAKE_HOLD;
  localparam int CW = $clog2(MAXV + 1);

  localparam logic [CW-1:0] IDLE_LAST =
    CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(WAKE_HOLD - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    GATED,
    WAKE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] hold_cnt;
  logic          wake;

  assign wake = wake_i | debug_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ACTIVE;
      idle_cnt     <= '0;
      hold_cnt     <= '0;
      clk_en_o     <= 1'b1;
      core_sleep_o <= 1'b0;
    end else begin
      case (state_q)
        ACTIVE: begin
          clk_en_o     <= 1'b1;
          core_sleep_o <= 1'b0;
          if (sleep_req_i && !wake) begin
            state_q  <= DRAIN;
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          if (wake || !sleep_req_i) begin
            state_q  <= ACTIVE;
            idle_cnt <= '0;
          end else if (busy_i) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_q      <= GATED;
            idle_cnt     <= '0;
            clk_en_o     <= 1'b0;
            core_sleep_o <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GATED: begin
          // sleep_req_i/busy_i come from the frozen domain here
          if (wake) begin
            state_q      <= WAKE;
            hold_cnt     <= '0;
            clk_en_o     <= 1'b1;
            core_sleep_o <= 1'b0;
          end
        end
        WAKE: begin
          clk_en_o     <= 1'b1;
          core_sleep_o <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state_q  <= ACTIVE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state_q      <= ACTIVE;
          idle_cnt     <= '0;
          hold_cnt     <= '0;
          clk_en_o     <= 1'b1;
          core_sleep_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef RVLAB_CG_STATS_EN
  logic [31:0] gated_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_q <= '0;
    end else if (state_q == GATED &&
                 gated_q != 32'hFFFF_FFFF) begin
      gated_q <= gated_q + 32'd1;
    end
  end

  assign gated_cycles_o = gated_q;
`else
  assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_cg_ctrl.sv
// Cycle-trace scoreboard bench for cv32e40p_sleep_cg_ctrl.
// Directed per-cycle vectors; monitor compares at each falling edge.
module tb_cv32e40p_sleep_cg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sleep_req_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        wake_i = 1'b0;
  logic        debug_req_i = 1'b0;
  logic        clk_en_o;
  logic        core_sleep_o;
  logic [31:0] gated_cycles_o;

  cv32e40p_sleep_cg_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_HOLD  (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sleep_req_i   (sleep_req_i),
    .busy_i        (busy_i),
    .wake_i        (wake_i),
    .debug_req_i   (debug_req_i),
    .clk_en_o      (clk_en_o),
    .core_sleep_o  (core_sleep_o),
    .gated_cycles_o(gated_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic        en;
    logic        sl;
    logic [31:0] gc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vec = 0;
  logic [31:0] gc_model = 0;

  // expected outputs observed during the cycle the inputs are applied
  task automatic cyc(input logic r, input logic s,
                     input logic b, input logic w,
                     input logic d, input logic en,
                     input logic sl, input int n = 1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst_ni      = r;
      sleep_req_i = s;
      busy_i      = b;
      wake_i      = w;
      debug_req_i = d;
      if (!r) gc_model = 0;
      e.id = vec;
      e.en = en;
      e.sl = sl;
`ifdef RVLAB_CG_STATS_EN
      e.gc = gc_model;
`else
      e.gc = 32'd0;
`endif
      sb.push_back(e);
      if (r && sl) gc_model = gc_model + 1;
      vec++;
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (clk_en_o !== e.en) begin
        n_bad++;
        $display("FAIL clk_en v%0d: got %b want %b",
                 e.id, clk_en_o, e.en);
      end
      n_cmp++;
      if (core_sleep_o !== e.sl) begin
        n_bad++;
        $display("FAIL core_sleep v%0d: got %b want %b",
                 e.id, core_sleep_o, e.sl);
      end
      n_cmp++;
      if (gated_cycles_o !== e.gc) begin
        n_bad++;
        $display("FAIL gated_cycles v%0d: got %0d want %0d",
                 e.id, gated_cycles_o, e.gc);
      end
    end
  end

  initial begin
    int guard;
    @(posedge clk_i);
    #1;
    // reset held, then idle with no sleep request
    cyc(0, 0, 0, 0, 0, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 1, 0, 4);

    // basic sleep: gate in cycle 5, stay gated, wake at 15
    cyc(1, 1, 0, 0, 0, 1, 0, 5);
    cyc(1, 1, 0, 0, 0, 0, 1, 3);
    cyc(1, 1, 1, 0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 0, 0, 1, 4);
    cyc(1, 1, 0, 1, 0, 0, 1, 1);
    // hold 2 cycles, ACTIVE, DRAIN x4, gated again
    cyc(1, 1, 0, 0, 0, 1, 0, 7);
    cyc(1, 1, 0, 0, 0, 0, 1, 2);
    cyc(1, 1, 0, 1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 1, 0, 2);

    // busy pulse on third idle cycle restarts the window
    cyc(1, 1, 0, 0, 0, 1, 0, 3);
    cyc(1, 1, 1, 0, 0, 1, 0, 1);
    cyc(1, 1, 0, 0, 0, 1, 0, 4);
    cyc(1, 1, 0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 3);

    // wake on final drain cycle aborts, then stays ACTIVE
    cyc(1, 1, 0, 0, 0, 1, 0, 4);
    cyc(1, 1, 0, 1, 0, 1, 0, 3);
    cyc(1, 1, 0, 0, 0, 1, 0, 5);
    cyc(1, 1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 3);

    // debug request with sleep request never leaves ACTIVE
    cyc(1, 1, 0, 0, 1, 1, 0, 8);
    cyc(1, 0, 0, 0, 0, 1, 0, 1);

    // sleep drop mid-drain aborts; re-request restarts count
    cyc(1, 1, 0, 0, 0, 1, 0, 3);
    cyc(1, 0, 0, 0, 0, 1, 0, 1);
    cyc(1, 1, 0, 0, 0, 1, 0, 5);
    cyc(1, 1, 0, 0, 0, 0, 1, 3);

    // reset mid-gated restores clock before any edge
    cyc(0, 1, 0, 0, 0, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 1, 0, 3);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk_i);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
